program_counter: RTL
====================

Name: program_counter

Overview:
Fetch-side program counter that drives pc_count into the instruction memory stage each cycle. It supports:
- sequential increment
- absolute branch and PC-relative branch
- call/return through a small hardware return-address stack
- stall hold and halt/resume control

It sits directly upstream of the instruction memory block; the decode/control logic drives its control inputs.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
STACK_DEPTH, 4, return-address stack entries (1..8); used only when CALL_STACK_EN is defined

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold PC, ignore all control inputs except halt_req
halt_req  input  1  enter HALT
resume  input  1  leave HALT
branch_en  input  1  absolute branch request
branch_target  input  8  absolute branch/call target
rel_en  input  1  relative branch request
rel_offset  input  8  signed two's-complement offset
call_en  input  1  push return address, jump to branch_target
ret_en  input  1  pop return address into PC
pc_count  output  8  current fetch address
pc_valid  output  1  pc_count is a real fetch this cycle
halted  output  1  FSM in HALT
stack_overflow  output  1  sticky push-on-full flag
stack_underflow  output  1  sticky pop-on-empty flag

Behaviour:
- Reset (reset=0, async):
  - pc_count=RESET_PC, pc_valid=0, halted=0
  - stack emptied, both sticky flags=0, FSM=BOOT
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle after reset release; pc_count held at RESET_PC; pc_valid=0; next state RUN unconditionally. Control inputs ignored, including halt_req.
  - RUN: pc_valid = ~stall. pc_count updates on the rising edge by priority (first true wins):
    1. halt_req: go HALT, pc held.
    2. stall: pc held.
    3. ret_en: pop. PC = popped value. If the stack is empty: stack_underflow<=1, PC = PC+1.
    4. call_en: push PC+1, PC = branch_target. If the stack is full: stack_overflow<=1, push dropped, jump still taken.
    5. branch_en: PC = branch_target.
    6. rel_en: PC = PC + sign_extend(rel_offset).
    7. Otherwise: PC = PC+1.
  - HALT: halted=1, pc_valid=0, pc held. resume=1 with halt_req=0 -> RUN next cycle, PC unchanged, so the next fetch re-issues the held address. halt_req and resume together -> stay HALT. Other inputs ignored.
- Arithmetic: all PC math is modulo 256. 8'hFF+1=8'h00; 8'h02 + 8'hFC(-4) = 8'hFE.
- Lower-priority requests coincident with a winning request are dropped, not queued. Example: call_en+ret_en together -> ret only, no push.
- Sticky flags clear only on reset.
- Mid-operation reset: immediately returns all state to reset values regardless of FSM state or stack occupancy.
- Latency: a control input sampled at edge N appears on pc_count after edge N; no combinational input-to-pc_count path.

Optional Feature:
Macro: PC_CALL_STACK_EN.
- Defined: the return-address stack, call/return semantics and both overflow/underflow flags are implemented as above.
- Undefined: no stack storage.
  - call_en behaves as branch_en (jump, no push).
  - ret_en is treated as absent and priority falls through.
  - stack_overflow and stack_underflow are tied to 0.
  - STACK_DEPTH is unused.

Test Plan:
- Reset, release, 4 idle cycles -> BOOT cycle pc=00 with pc_valid=0, then pc_valid=1 and pc = 00,01,02,03.
- Load pc=FE, idle 3 cycles -> FE,FF,00 (wrap). At pc=10, apply rel_en with offset FC -> pc=0C next cycle.
- PC_CALL_STACK_EN, STACK_DEPTH=4, five calls to target 40 from pc=05 -> fifth call still jumps to 40 and sets stack_overflow=1. Five rets -> pc=41,41,41,06, then the fifth ret on empty gives stack_underflow=1 with pc=07.
- stall=1 for 3 cycles with branch_en=1, target 80 -> pc held, pc_valid=0, no branch taken. halt_req during stall -> halted=1 next cycle.
- In HALT at pc=22, assert halt_req+resume together -> stays HALT. resume alone -> RUN, pc_count=22 with pc_valid=1, then 23.
- Assert reset mid-run at pc=57 with 2 stack entries -> pc=RESET_PC immediately (asynchronously). Stack empty afterwards: first ret flags underflow.

Source files
------------

// File: rtl/program_counter_if.sv
// program_counter_if: control and status bundle between the decode/control
// logic (master) and the fetch-side program counter (slave).
interface program_counter_if;
   logic       stall;
   logic       halt_req;
   logic       resume;
   logic       branch_en;
   logic [7:0] branch_target;
   logic       rel_en;
   logic [7:0] rel_offset;
   logic       call_en;
   logic       ret_en;
   logic [7:0] pc_count;
   logic       pc_valid;
   logic       halted;
   logic       stack_overflow;
   logic       stack_underflow;

   // Decode/control side: drives requests, observes the fetch address.
   modport master (
      output stall, halt_req, resume, branch_en, branch_target,
             rel_en, rel_offset, call_en, ret_en,
      input  pc_count, pc_valid, halted, stack_overflow, stack_underflow
   );

   // Program counter side.
   modport slave (
      input  stall, halt_req, resume, branch_en, branch_target,
             rel_en, rel_offset, call_en, ret_en,
      output pc_count, pc_valid, halted, stack_overflow, stack_underflow
   );
endinterface

// File: rtl/program_counter.sv
// program_counter: fetch-side 8-bit PC with sequential increment, absolute
// and relative branches, stall/halt control and an optional hardware
// return-address stack.
// Optional feature macro: PC_CALL_STACK_EN
//   defined   -> call/ret through a STACK_DEPTH-entry return-address stack
//                with sticky overflow/underflow flags.
//   undefined -> call_en acts as an absolute branch, ret_en is ignored and
//                both stack flags read 0.
// All PC arithmetic is modulo 256. pc_count is always a register output.
module program_counter #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter int         STACK_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   program_counter_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [7:0] pc_reg;
   logic [7:0] pc_next;
   logic [7:0] pc_inc;
   logic [7:0] pc_rel;

   assign pc_inc = pc_reg + 8'd1;
   // An 8-bit wrap-around add of the raw offset gives exactly the result of
   // adding the sign-extended offset modulo 256.
   assign pc_rel = pc_reg + bus.rel_offset;

`ifdef PC_CALL_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [SP_W-1:0]  sp_reg;
   logic             ovf_reg;
   logic             unf_reg;
   logic [7:0]       stack_mem [STACK_DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;
   logic             stack_empty;
   logic             stack_full;
   logic [7:0]       stack_top;
   logic             push_req;
   logic             pop_req;
   logic             ovf_set;
   logic             unf_set;

   // sp_reg counts occupied entries; the next free slot is sp_reg and the
   // top of stack is sp_reg-1. wr_idx is only used when not full.
   assign wr_idx      = IDX_W'(sp_reg);
   assign top_idx     = IDX_W'(sp_reg - 1'b1);
   assign stack_empty = (sp_reg == '0);
   assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
   assign stack_top   = stack_mem[top_idx];
`endif

   // Next-state and next-PC selection; first matching request wins.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
`ifdef PC_CALL_STACK_EN
      push_req   = 1'b0;
      pop_req    = 1'b0;
      ovf_set    = 1'b0;
      unf_set    = 1'b0;
`endif
      unique case (state_reg)
         ST_BOOT: begin
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (bus.halt_req) begin
               state_next = ST_HALT;
            end else if (bus.stall) begin
               pc_next = pc_reg;
            end
`ifdef PC_CALL_STACK_EN
            else if (bus.ret_en) begin
               if (stack_empty) begin
                  unf_set = 1'b1;
                  pc_next = pc_inc;
               end else begin
                  pop_req = 1'b1;
                  pc_next = stack_top;
               end
            end else if (bus.call_en) begin
               // The jump is taken even when the push has to be dropped.
               pc_next = bus.branch_target;
               if (stack_full) begin
                  ovf_set = 1'b1;
               end else begin
                  push_req = 1'b1;
               end
            end
`else
            else if (bus.call_en) begin
               pc_next = bus.branch_target;
            end
`endif
            else if (bus.branch_en) begin
               pc_next = bus.branch_target;
            end else if (bus.rel_en) begin
               pc_next = pc_rel;
            end else begin
               pc_next = pc_inc;
            end
         end
         ST_HALT: begin
            // Resume wins only when halt_req is not also asserted; the PC
            // is untouched so the held address is fetched again.
            if (bus.resume && !bus.halt_req) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_BOOT;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_BOOT;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

`ifdef PC_CALL_STACK_EN
   // Return-address storage; contents need no reset because sp_reg gates
   // every read.
   always_ff @(posedge clk) begin
      if (push_req) begin
         stack_mem[wr_idx] <= pc_inc;
      end
   end

   // Stack occupancy and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_reg  <= '0;
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else begin
         if (push_req) begin
            sp_reg <= sp_reg + 1'b1;
         end else if (pop_req) begin
            sp_reg <= sp_reg - 1'b1;
         end
         if (ovf_set) begin
            ovf_reg <= 1'b1;
         end
         if (unf_set) begin
            unf_reg <= 1'b1;
         end
      end
   end

   assign bus.stack_overflow  = ovf_reg;
   assign bus.stack_underflow = unf_reg;
`else
   assign bus.stack_overflow  = 1'b0;
   assign bus.stack_underflow = 1'b0;
`endif

   assign bus.pc_count = pc_reg;
   assign bus.pc_valid = (state_reg == ST_RUN) && !bus.stall;
   assign bus.halted   = (state_reg == ST_HALT);

endmodule
